// File: rtl/npc_redirect_queue.sv
// -----------------------------------------------------------------------------
// npc_redirect_queue
// Next-PC generator for the fetch front end. Resolves the dynamic next PC from
// a one-hot source select (trap/CSR, jalr, jal, branch, snpc) and offers it to
// IF over valid/ready. While IF stalls, up to DEPTH targets are queued so no
// redirect is lost; an accepted trap flushes the queue and is presented at once.
//
// Ports
//   I_clk, I_rst     clock, synchronous active-high reset
//   I_req_valid      decode presents an instruction whose next PC is resolved
//   O_req_ready      request can be accepted this cycle
//   I_sel[4:0]       source select: [4] trap, [3] jalr, [2] jal, [1] br, [0] snpc
//   I_rs1_data       jalr base (XLEN)
//   I_imm            offset (XLEN)
//   I_pc, I_snpc     PC of resolving instruction, sequential next PC
//   I_trap_pc        trap/xret target (XLEN)
//   O_pc_valid       O_pc is a valid fetch target
//   I_pc_ready       IF accepts O_pc
//   O_pc             next fetch PC
//   O_misalign       presented target has bit1 set
//   O_count          number of buffered targets
// -----------------------------------------------------------------------------
module npc_redirect_queue #(
    parameter int              XLEN     = 64,
    parameter int              PC_W     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h80000000),
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_req_valid,
    output logic            O_req_ready,
    input  logic [4:0]      I_sel,
    input  logic [XLEN-1:0] I_rs1_data,
    input  logic [XLEN-1:0] I_imm,
    input  logic [PC_W-1:0] I_pc,
    input  logic [PC_W-1:0] I_snpc,
    input  logic [XLEN-1:0] I_trap_pc,
    output logic            O_pc_valid,
    input  logic            I_pc_ready,
    output logic [PC_W-1:0] O_pc,
    output logic            O_misalign,
    output logic [CW-1:0]   O_count
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage: {misalign, target}
    logic [PC_W:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count;
    logic [PC_W-1:0] r_last_pc;
    logic            r_last_mis;

    logic [PC_W-1:0] w_base, w_sum, w_tgt;
    logic            w_empty, w_full, w_accept, w_trap, w_push, w_pop;

    // Target computation; trap > jalr > jal|branch > snpc (also covers sel==0)
    always_comb begin
        w_base = I_sel[3] ? I_rs1_data[PC_W-1:0] : I_pc;
        w_sum  = w_base + I_imm[PC_W-1:0];
        if (I_sel[4])                 w_tgt = I_trap_pc[PC_W-1:0];
        else if (I_sel[3])            w_tgt = {w_sum[PC_W-1:1], 1'b0};
        else if (I_sel[2] | I_sel[1]) w_tgt = w_sum;
        else                          w_tgt = I_snpc;
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == DEPTH_C);
    // A trap is always accepted: it discards the queue, so it never overflows.
    assign O_req_ready = !w_full || I_sel[4];
    assign w_accept    = I_req_valid && O_req_ready;
    assign w_trap      = w_accept && I_sel[4];
    assign w_pop       = I_pc_ready && !w_empty;
    // Bypass value taken by IF in the same cycle never enters the queue.
    assign w_push      = w_accept && !(w_empty && I_pc_ready);
    assign O_count     = r_count;

    always_comb begin
        O_pc_valid = 1'b1;
        O_pc       = w_tgt;
        O_misalign = w_tgt[1];
        if (w_trap) begin
            O_pc       = w_tgt;
            O_misalign = w_tgt[1];
        end else if (!w_empty) begin
            O_pc       = r_mem[r_head][PC_W-1:0];
            O_misalign = r_mem[r_head][PC_W];
        end else if (!I_req_valid) begin
            O_pc_valid = 1'b0;
            O_pc       = r_last_pc;
            O_misalign = r_last_mis;
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge I_clk) begin
        if (w_trap && !I_pc_ready)
            r_mem[0] <= {w_tgt[1], w_tgt};
        else if (!w_trap && w_push)
            r_mem[r_tail] <= {w_tgt[1], w_tgt};
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_pc  <= RESET_PC;
            r_last_mis <= 1'b0;
        end else begin
            if (O_pc_valid) begin
                r_last_pc  <= O_pc;
                r_last_mis <= O_misalign;
            end
            if (w_trap) begin
                // Flush; keep only the trap target if IF did not take it.
                r_head <= '0;
                if (I_pc_ready) begin
                    r_tail  <= '0;
                    r_count <= '0;
                end else begin
                    r_tail  <= ptr_inc('0);
                    r_count <= CW'(1);
                end
            end else begin
                if (w_push) r_tail <= ptr_inc(r_tail);
                if (w_pop)  r_head <= ptr_inc(r_head);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
